// File: rtl/hazard_if.sv
// hazard_if: decode-stage flags, flush and issue/retire/stall outputs of the hazard scoreboard
interface hazard_if #(parameter int REG_AW = 3);
    logic              id_valid;
    logic              id_rarf;
    logic              id_rbrf;
    logic              id_rawf;
    logic              id_rbwf;
    logic [REG_AW-1:0] id_ra;
    logic [REG_AW-1:0] id_rb;
    logic              flush;
    logic              id_ready;
    logic              issue;
    logic              retire_valid;
    logic [REG_AW-1:0] retire_dst;
    logic [15:0]       stall_cnt;
    modport master (
        output id_valid, id_rarf, id_rbrf, id_rawf, id_rbwf, id_ra, id_rb, flush,
        input  id_ready, issue, retire_valid, retire_dst, stall_cnt
    );
    modport slave (
        input  id_valid, id_rarf, id_rbrf, id_rawf, id_rbwf, id_ra, id_rb, flush,
        output id_ready, issue, retire_valid, retire_dst, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW-hazard stall/issue control over a DEPTH-slot shift register of in-flight destinations
module hazard_scoreboard #(
    parameter int DEPTH       = 4,
    parameter int REG_AW      = 3,
    parameter int BYPASS_FROM = 4,
    parameter int KILL_DEPTH  = 1
) (
    input logic     clk,
    input logic     rst,
    hazard_if.slave io_bus
);
    logic [DEPTH-1:0]  r_wv;
    logic [REG_AW-1:0] r_dst [DEPTH];
    logic [15:0]       r_stall_cnt;
    logic              w_match_a;
    logic              w_match_b;
    logic              w_hazard;
    logic              w_issue;
    // Only slots not yet covered by forwarding can block a reader
    always_comb begin
        w_match_a = 1'b0;
        w_match_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i < BYPASS_FROM) begin
                w_match_a = w_match_a | (r_wv[i] & (r_dst[i] == io_bus.id_ra));
                w_match_b = w_match_b | (r_wv[i] & (r_dst[i] == io_bus.id_rb));
            end
        end
    end
    assign w_hazard = io_bus.id_valid & ((io_bus.id_rarf & w_match_a) | (io_bus.id_rbrf & w_match_b));
    assign w_issue  = io_bus.id_valid & ~w_hazard & ~io_bus.flush;
    assign io_bus.id_ready     = ~w_hazard;
    assign io_bus.issue        = w_issue;
    assign io_bus.retire_valid = r_wv[DEPTH-1];
    assign io_bus.retire_dst   = r_dst[DEPTH-1];
    assign io_bus.stall_cnt    = r_stall_cnt;
    // Advance every slot each cycle; a flush turns the youngest slots into bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wv <= '0;
            for (int i = 0; i < DEPTH; i++) r_dst[i] <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                r_wv[i]  <= (io_bus.flush && i <= KILL_DEPTH) ? 1'b0 : r_wv[i-1];
                r_dst[i] <= (io_bus.flush && i <= KILL_DEPTH) ? '0 : r_dst[i-1];
            end
            r_wv[0]  <= w_issue & (io_bus.id_rawf | io_bus.id_rbwf);
            r_dst[0] <= w_issue ? (io_bus.id_rawf ? io_bus.id_ra : io_bus.id_rb) : '0;
        end
    end
    // Saturating count of cycles lost to hazards; flushed cycles are not stalls
    always_ff @(posedge clk) begin
        if (rst) r_stall_cnt <= '0;
        else if (w_hazard && !io_bus.flush && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: scoreboard bench with a pending-write list model, plus bypass and saturation instances
module tb_hazard_scoreboard;
    localparam int D  = 4;
    localparam int BF = 4;
    localparam int KD = 1;

    typedef struct { logic ready; logic issue; logic [15:0] cnt; } exp_t;
    typedef struct { int age; logic [2:0] dst; } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;
    bit   mon_en = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   m_cnt = 0;
    exp_t exp_q[$];
    logic [2:0] ret_q[$];
    ent_t pend[$];

    always #5 clk = ~clk;

    hazard_if #(.REG_AW(3)) hb ();
    hazard_if #(.REG_AW(3)) hbp ();
    hazard_if #(.REG_AW(3)) hs ();

    hazard_scoreboard #(.DEPTH(D), .REG_AW(3), .BYPASS_FROM(BF), .KILL_DEPTH(KD))
        u_dut (.clk(clk), .rst(rst), .io_bus(hb));
    hazard_scoreboard #(.DEPTH(4), .REG_AW(3), .BYPASS_FROM(1), .KILL_DEPTH(1))
        u_byp (.clk(clk), .rst(rst_b), .io_bus(hbp));
    hazard_scoreboard #(.DEPTH(16), .REG_AW(3), .BYPASS_FROM(16), .KILL_DEPTH(1))
        u_sat (.clk(clk), .rst(rst_s), .io_bus(hs));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit blocked(input logic [2:0] r);
        foreach (pend[k]) if (pend[k].age < BF && pend[k].dst == r) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: pending writes age by one per edge, vanish after DEPTH cycles, young ones die on flush
    task automatic advance(input bit haz, input bit iss, input bit fl, input bit rs, input bit w, input logic [2:0] d);
        ent_t nq[$];
        if (rs) begin
            pend.delete();
            m_cnt = 0;
        end else begin
            if (haz && !fl && m_cnt < 65535) m_cnt++;
            foreach (pend[k])
                if (!(fl && pend[k].age < KD) && pend[k].age + 1 < D) nq.push_back('{pend[k].age + 1, pend[k].dst});
            if (iss && w) nq.push_back('{0, d});
            pend = nq;
            foreach (pend[k]) if (pend[k].age == D - 1) ret_q.push_back(pend[k].dst);
        end
    endtask

    task automatic step(input bit v, input bit rarf, input bit rbrf, input bit rawf, input bit rbwf,
                        input logic [2:0] ra, input logic [2:0] rb, input bit fl, input bit rs, output bit iss);
        bit haz;
        hb.id_valid = v; hb.id_rarf = rarf; hb.id_rbrf = rbrf; hb.id_rawf = rawf; hb.id_rbwf = rbwf;
        hb.id_ra = ra; hb.id_rb = rb; hb.flush = fl; rst = rs;
        haz = v && ((rarf && blocked(ra)) || (rbrf && blocked(rb)));
        iss = v && !haz && !fl;
        exp_q.push_back('{!haz, iss, 16'(m_cnt)});
        @(posedge clk); #1;
        advance(haz, iss, fl, rs, rawf || rbwf, rawf ? ra : rb);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("id_ready", hb.id_ready, e.ready);
                check("issue", hb.issue, e.issue);
                check("stall_cnt", hb.stall_cnt, e.cnt);
            end
            check("retire_valid", hb.retire_valid, ret_q.size() != 0);
            if (ret_q.size() != 0) check("retire_dst", hb.retire_dst, ret_q.pop_front());
        end
    end

    task automatic main_seq();
        bit iss;
        int n;
        hb.id_valid = 1; hb.id_rarf = 0; hb.id_rbrf = 0; hb.id_rawf = 0; hb.id_rbwf = 0;
        hb.id_ra = 0; hb.id_rb = 0; hb.flush = 0;
        @(posedge clk); #1;
        mon_en = 1'b1;
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, iss);
        step(1, 1, 1, 0, 0, 0, 0, 0, 1, iss);
        check("reset_retire_dst", hb.retire_dst, 3'd0);
        check("reset_stall_cnt", hb.stall_cnt, 16'd0);
        step(1, 0, 0, 1, 0, 3'd3, 0, 0, 0, iss);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
        n = 0;
        do begin
            step(1, 0, 1, 0, 0, 0, 3'd3, 0, 0, iss);
            n++;
        end while (!iss && n < 10);
        check("raw_stall_cycles", n - 1, 3);
        check("raw_stall_cnt", hb.stall_cnt, 16'd3);
        step(1, 0, 0, 0, 1, 0, 3'd2, 0, 0, iss);
        check("nohaz_issue_w", iss, 1);
        step(1, 1, 1, 0, 0, 3'd5, 3'd6, 0, 0, iss);
        check("nohaz_issue_r", iss, 1);
        repeat (D + 1) step(0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
        check("nohaz_stall_cnt", hb.stall_cnt, 16'd3);
        step(1, 0, 0, 1, 0, 3'd1, 0, 0, 0, iss);
        step(1, 1, 0, 0, 0, 3'd1, 0, 1, 0, iss);
        check("flush_no_issue", iss, 0);
        step(1, 1, 0, 0, 0, 3'd1, 0, 0, 0, iss);
        check("flush_reader_issues", iss, 1);
        repeat (D + 1) step(0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0, iss);
        repeat (D + 1) step(0, 0, 0, 0, 0, 0, 0, 0, 0, iss);
        @(negedge clk); #1;
        mon_en = 1'b0;
        check("exp_q_drained", exp_q.size(), 0);
        check("ret_q_drained", ret_q.size(), 0);
    endtask

    task automatic side_seq();
        hbp.id_valid = 1; hbp.id_rarf = 0; hbp.id_rbrf = 0; hbp.id_rawf = 0; hbp.id_rbwf = 0;
        hbp.id_ra = 0; hbp.id_rb = 0; hbp.flush = 0;
        hs.id_valid = 1; hs.id_rarf = 1; hs.id_rbrf = 0; hs.id_rawf = 1; hs.id_rbwf = 0;
        hs.id_ra = 3'd1; hs.id_rb = 0; hs.flush = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_b = 0; rst_s = 0;
        hbp.id_rawf = 1; hbp.id_ra = 3'd4;
        @(posedge clk); #1;
        hbp.id_valid = 0; hbp.id_rawf = 0;
        @(posedge clk); #1;
        hbp.id_valid = 1; hbp.id_rarf = 1;
        #3;
        check("byp_ready", hbp.id_ready, 1);
        check("byp_issue", hbp.issue, 1);
        @(posedge clk); #1;
        hbp.id_valid = 0;
        check("byp_stall_cnt", hbp.stall_cnt, 16'd0);
        repeat (15) @(posedge clk);
        #1;
        check("sat_early_cnt", hs.stall_cnt, 16'd16);
        repeat (70000 - 17) @(posedge clk);
        #1;
        check("sat_cnt", hs.stall_cnt, 16'hFFFF);
        repeat (100) @(posedge clk);
        #1;
        check("sat_hold", hs.stall_cnt, 16'hFFFF);
    endtask

    initial begin
        fork
            main_seq();
            side_seq();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
